spart_param: RTL and testbench

SPART_PARAM -- requirements
Module: spart_param

---
 rtl/spart_pkg.sv | 13 +
 rtl/spart_fifo.sv | 43 ++++
 rtl/spart_param.sv | 217 +++++++++++++++++++++
 tb/tb_spart_param.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// spart_pkg: register map, control/error bit positions, FSM states and reset baud divisor for the SPART
package spart_pkg;
  localparam logic [2:0] A_DATA = 3'd0, A_TXCNT = 3'd1, A_DBL = 3'd2, A_DBH = 3'd3;
  localparam logic [2:0] A_RXCNT = 3'd4, A_CTRL = 3'd5, A_ERR = 3'd6;
  localparam int C_PEN = 0, C_PODD = 1, C_TWO = 2, C_LOOP = 3, C_RXIE = 4, C_TXIE = 5, C_ERRIE = 6;
  localparam int E_TXOVF = 0, E_RXOVR = 1, E_FRM = 2, E_PAR = 3;
  localparam logic [12:0] DB_RESET_DEF = 13'h01B2;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP1, TX_STOP2} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;
  function automatic logic [12:0] bit_period(input logic [12:0] db);
    return db < 13'd2 ? 13'd2 : db;
  endfunction
endpackage

// File: rtl/spart_fifo.sv
// spart_fifo: circular-buffer FIFO (push/pop/full/empty/count); push while full succeeds only alongside a pop
module spart_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_pop, do_push;
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = mem_q[rd_q];
  assign wr_d = do_push ? wr_q + AW'(1) : wr_q;
  assign rd_d = do_pop ? rd_q + AW'(1) : rd_q;
  assign cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/spart_param.sv
// spart_param: bus-mapped UART (DATA/TXCNT/DBL/DBH/RXCNT/CTRL/ERR) with TX/RX FIFOs, parity, loopback, level irq
module spart_param import spart_pkg::*; #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          DATA_BITS = 8,
  parameter logic [12:0] DB_RESET = DB_RESET_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs_n,
  input  logic       iorw_n,
  input  logic [2:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       TX,
  input  logic       RX,
  output logic       tx_q_full,
  output logic       rx_q_empty,
  output logic       irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(DATA_BITS);
  logic wr, rd, tx_push, tx_pop, tx_full, tx_empty, rx_pop, rx_full, rx_empty;
  logic rx_valid, frm_err, par_err, tx_ovf, rx_ovr, tx_load, tx_tick, rx_tick, tx_line, rx_in;
  logic [DATA_BITS-1:0] tx_head, rx_head;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [7:0] rdata, dbl_q, dbl_d;
  logic [4:0] dbh_q, dbh_d;
  logic [6:0] ctrl_q, ctrl_d;
  logic [3:0] err_q, err_d;
  logic [12:0] db;
  logic irq_q, irq_d;
  tx_state_e tx_st_q, tx_st_d;
  rx_state_e rx_st_q, rx_st_d;
  logic [12:0] tx_tmr_q, tx_tmr_d, tx_per_q, tx_per_d, rx_tmr_q, rx_tmr_d, rx_per_q, rx_per_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_two_q, tx_two_d;
  logic rx_par_q, rx_par_d, rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  assign wr = ~iocs_n & ~iorw_n;
  assign rd = ~iocs_n & iorw_n;
  assign databus = rd ? rdata : 8'bz;
  assign tx_push = wr & (ioaddr == A_DATA);
  assign rx_pop = rd & (ioaddr == A_DATA);
  assign db = {dbh_q, dbl_q};
  always_comb begin
    rdata = '0;
    case (ioaddr)
      A_DATA:  rdata = 8'(rx_empty ? '0 : rx_head);
      A_TXCNT: rdata = 8'(FIFO_DEPTH) - 8'(tx_cnt);
      A_DBL:   rdata = dbl_q;
      A_DBH:   rdata = {3'b0, dbh_q};
      A_RXCNT: rdata = 8'(rx_cnt);
      A_CTRL:  rdata = {1'b0, ctrl_q};
      A_ERR:   rdata = {4'b0, err_q};
      default: rdata = '0;
    endcase
  end
  assign dbl_d = (wr & (ioaddr == A_DBL)) ? databus : dbl_q;
  assign dbh_d = (wr & (ioaddr == A_DBH)) ? databus[4:0] : dbh_q;
  assign ctrl_d = (wr & (ioaddr == A_CTRL)) ? databus[6:0] : ctrl_q;
  assign tx_ovf = tx_push & tx_full & ~tx_pop;
  assign rx_ovr = rx_valid & rx_full & ~rx_pop;
  assign err_d = {par_err, frm_err, rx_ovr, tx_ovf} | (err_q & ~((wr & (ioaddr == A_ERR)) ? databus[3:0] : 4'b0));
  assign irq_d = (ctrl_q[C_RXIE] & ~rx_empty) | (ctrl_q[C_TXIE] & tx_empty) | (ctrl_q[C_ERRIE] & |err_q);
  assign irq = irq_q;
  assign tx_q_full = tx_full;
  assign rx_q_empty = rx_empty;
  spart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(tx_push), .pop_i(tx_pop), .din_i(databus[DATA_BITS-1:0]),
    .dout_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
  );
  spart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(rx_valid), .pop_i(rx_pop), .din_i(rx_sh_q),
    .dout_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
  );
  // a new frame is loaded from IDLE or straight out of the final stop bit, so back-to-back frames have no gap
  assign tx_tick = tx_tmr_q == tx_per_q - 13'd1;
  assign tx_load = ~tx_empty & ((tx_st_q == TX_IDLE) | (tx_tick & (((tx_st_q == TX_STOP1) & ~tx_two_q) | (tx_st_q == TX_STOP2))));
  assign tx_pop = tx_load;
  assign tx_line = (tx_st_q == TX_START) ? 1'b0 : (tx_st_q == TX_DATA) ? tx_sh_q[0] : (tx_st_q == TX_PAR) ? tx_par_q : 1'b1;
  assign TX = tx_line | ctrl_q[C_LOOP];
  always_comb begin
    tx_st_d = tx_st_q;
    tx_tmr_d = tx_tick ? '0 : tx_tmr_q + 13'd1;
    tx_per_d = tx_per_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_par_d = tx_par_q;
    tx_pen_d = tx_pen_q;
    tx_two_d = tx_two_q;
    if (tx_load) begin
      tx_st_d = TX_START;
      tx_tmr_d = '0;
      tx_per_d = bit_period(db);
      tx_sh_d = tx_head;
      tx_par_d = ^tx_head ^ ctrl_q[C_PODD];
      tx_pen_d = ctrl_q[C_PEN];
      tx_two_d = ctrl_q[C_TWO];
    end else if (tx_st_q == TX_IDLE) tx_tmr_d = '0;
    else if (tx_tick) begin
      case (tx_st_q)
        TX_START: begin
          tx_st_d = TX_DATA;
          tx_bit_d = '0;
        end
        TX_DATA: begin
          tx_sh_d = tx_sh_q >> 1;
          tx_bit_d = tx_bit_q + BW'(1);
          if (tx_bit_q == BW'(DATA_BITS - 1)) tx_st_d = tx_pen_q ? TX_PAR : TX_STOP1;
        end
        TX_PAR:   tx_st_d = TX_STOP1;
        TX_STOP1: tx_st_d = tx_two_q ? TX_STOP2 : TX_IDLE;
        default:  tx_st_d = TX_IDLE;
      endcase
    end
  end
  // START waits half a period to land mid-bit; every later bit is one full period on
  assign rx_in = ctrl_q[C_LOOP] ? tx_line : RX;
  assign rx_tick = rx_tmr_q == ((rx_st_q == RX_START) ? (rx_per_q >> 1) - 13'd1 : rx_per_q - 13'd1);
  always_comb begin
    rx_st_d = rx_st_q;
    rx_tmr_d = rx_tick ? '0 : rx_tmr_q + 13'd1;
    rx_per_d = rx_per_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_par_d = rx_par_q;
    rx_pen_d = rx_pen_q;
    rx_odd_d = rx_odd_q;
    rx_valid = 1'b0;
    frm_err = 1'b0;
    par_err = 1'b0;
    if (rx_st_q == RX_IDLE) begin
      rx_tmr_d = '0;
      if (rx_prev_q & ~rx_s2_q) begin
        rx_st_d = RX_START;
        rx_per_d = bit_period(db);
        rx_pen_d = ctrl_q[C_PEN];
        rx_odd_d = ctrl_q[C_PODD];
      end
    end else if (rx_tick) begin
      case (rx_st_q)
        RX_START: begin
          rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
          rx_bit_d = '0;
        end
        RX_DATA: begin
          rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
          rx_bit_d = rx_bit_q + BW'(1);
          if (rx_bit_q == BW'(DATA_BITS - 1)) rx_st_d = rx_pen_q ? RX_PAR : RX_STOP;
        end
        RX_PAR: begin
          rx_par_d = rx_s2_q;
          rx_st_d = RX_STOP;
        end
        default: begin
          rx_st_d = RX_IDLE;
          frm_err = ~rx_s2_q;
          par_err = rx_s2_q & rx_pen_q & (rx_par_q != (^rx_sh_q ^ rx_odd_q));
          rx_valid = rx_s2_q & ~par_err;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dbl_q <= DB_RESET[7:0];
      dbh_q <= DB_RESET[12:8];
      ctrl_q <= '0;
      err_q <= '0;
      irq_q <= 1'b0;
      tx_st_q <= TX_IDLE;
      tx_tmr_q <= '0;
      tx_per_q <= 13'd2;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_par_q <= 1'b0;
      tx_pen_q <= 1'b0;
      tx_two_q <= 1'b0;
      rx_st_q <= RX_IDLE;
      rx_tmr_q <= '0;
      rx_per_q <= 13'd2;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_par_q <= 1'b0;
      rx_pen_q <= 1'b0;
      rx_odd_q <= 1'b0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      dbl_q <= dbl_d;
      dbh_q <= dbh_d;
      ctrl_q <= ctrl_d;
      err_q <= err_d;
      irq_q <= irq_d;
      tx_st_q <= tx_st_d;
      tx_tmr_q <= tx_tmr_d;
      tx_per_q <= tx_per_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      tx_par_q <= tx_par_d;
      tx_pen_q <= tx_pen_d;
      tx_two_q <= tx_two_d;
      rx_st_q <= rx_st_d;
      rx_tmr_q <= rx_tmr_d;
      rx_per_q <= rx_per_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_par_q <= rx_par_d;
      rx_pen_q <= rx_pen_d;
      rx_odd_q <= rx_odd_d;
      rx_s1_q <= rx_in;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end
endmodule

// File: tb/tb_spart_param.sv
// tb_spart_param: directed scoreboard bench for spart_param
module tb_spart_param;
  import spart_pkg::*;
  localparam int BP = 16;
  logic clk = 1'b0, rst_n = 1'b0, iocs_n = 1'b1, iorw_n = 1'b1, RX = 1'b1, tb_oe = 1'b0;
  logic [2:0] ioaddr = 3'd0;
  logic [7:0] tb_d = 8'd0;
  wire [7:0] databus;
  logic TX, tx_q_full, rx_q_empty, irq;
  int vecs = 0, errs = 0, cyc = 0;
  logic [7:0] sb[$];
  assign databus = tb_oe ? tb_d : 8'bz;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  spart_param dut (
    .clk(clk), .rst_n(rst_n), .iocs_n(iocs_n), .iorw_n(iorw_n), .ioaddr(ioaddr), .databus(databus),
    .TX(TX), .RX(RX), .tx_q_full(tx_q_full), .rx_q_empty(rx_q_empty), .irq(irq)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs_n = 1'b0; iorw_n = 1'b0; ioaddr = a; tb_d = d; tb_oe = 1'b1;
    @(posedge clk);
    #1 iocs_n = 1'b1; iorw_n = 1'b1; tb_oe = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs_n = 1'b0; iorw_n = 1'b1; ioaddr = a;
    #1 d = databus;
    @(posedge clk);
    #1 iocs_n = 1'b1;
  endtask
  task automatic exp_rd(input string tag, input logic [2:0] a, input logic [31:0] e);
    logic [7:0] v;
    rd(a, v);
    chk(tag, 32'(v), e);
  endtask
  task automatic rd_sb(input string tag);
    logic [7:0] v;
    logic [7:0] e;
    e = 'x;
    if (sb.size() != 0) e = sb.pop_front();
    rd(A_DATA, v);
    chk(tag, 32'(v), 32'(e));
  endtask
  task automatic wait_rx(input int n, output int at);
    logic [7:0] v;
    at = -1;
    for (int i = 0; i < 3000; i++) begin
      rd(A_RXCNT, v);
      if (v == 8'(n)) begin
        at = cyc;
        break;
      end
    end
    chk("rxcnt_wait", 32'(at != -1), 1);
  endtask
  task automatic send(input logic [7:0] d, input bit pen, input bit pb, input bit stop);
    @(negedge clk);
    RX = 1'b0;
    repeat (BP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (BP) @(negedge clk);
    end
    if (pen) begin
      RX = pb;
      repeat (BP) @(negedge clk);
    end
    RX = stop;
    repeat (BP) @(negedge clk);
    RX = 1'b1;
    repeat (2 * BP) @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vecs);
    $fatal(1, "watchdog");
  end
  initial begin
    int t1, t2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_tx", 32'(TX), 1);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_full", 32'(tx_q_full), 0);
    chk("rst_empty", 32'(rx_q_empty), 1);
    exp_rd("rst_dbl", A_DBL, 'hB2);
    exp_rd("rst_dbh", A_DBH, 'h01);
    exp_rd("rst_ctrl", A_CTRL, 0);
    exp_rd("rst_err", A_ERR, 0);
    exp_rd("rst_txcnt", A_TXCNT, 8);
    exp_rd("rst_rxcnt", A_RXCNT, 0);
    exp_rd("rsvd", 3'd7, 0);
    wr(A_DBL, 8'd16);
    wr(A_DBH, 8'd0);
    wr(A_CTRL, 8'h09);
    exp_rd("ctrl_rb", A_CTRL, 'h09);
    wr(A_DATA, 8'h55);
    sb.push_back(8'h55);
    wr(A_DATA, 8'hA3);
    sb.push_back(8'hA3);
    repeat (20) @(negedge clk);
    chk("loop_tx_high", 32'(TX), 1);
    wait_rx(1, t1);
    wait_rx(2, t2);
    chk("frame_spacing", t2 - t1, 11 * BP);
    rd_sb("loop_rx0");
    exp_rd("loop_rxcnt1", A_RXCNT, 1);
    rd_sb("loop_rx1");
    exp_rd("loop_rxcnt0", A_RXCNT, 0);
    wr(A_CTRL, 8'h00);
    wr(A_DBL, 8'hFF);
    wr(A_DBH, 8'h1F);
    for (int i = 0; i < 10; i++) wr(A_DATA, 8'(8'h10 + i));
    chk("tx_full", 32'(tx_q_full), 1);
    exp_rd("txcnt_full", A_TXCNT, 0);
    exp_rd("err_txovf", A_ERR, 'h01);
    chk("tx_start_low", 32'(TX), 0);
    wr(A_ERR, 8'h01);
    exp_rd("err_clr", A_ERR, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_tx", 32'(TX), 1);
    chk("abort_full", 32'(tx_q_full), 0);
    exp_rd("abort_txcnt", A_TXCNT, 8);
    exp_rd("abort_dbl", A_DBL, 'hB2);
    repeat (50) @(negedge clk);
    chk("abort_idle", 32'(TX), 1);
    wr(A_DBL, 8'd16);
    wr(A_DBH, 8'd0);
    wr(A_CTRL, 8'h40);
    send(8'hC5, 1'b0, 1'b0, 1'b0);
    exp_rd("frm_err", A_ERR, 'h04);
    exp_rd("frm_rxcnt", A_RXCNT, 0);
    chk("frm_irq", 32'(irq), 1);
    wr(A_ERR, 8'h0F);
    repeat (2) @(negedge clk);
    chk("irq_clr", 32'(irq), 0);
    wr(A_CTRL, 8'h03);
    send(8'h0F, 1'b1, 1'b0, 1'b1);
    exp_rd("par_err", A_ERR, 'h08);
    exp_rd("par_rxcnt", A_RXCNT, 0);
    wr(A_ERR, 8'h0F);
    sb.push_back(8'h0F);
    send(8'h0F, 1'b1, 1'b1, 1'b1);
    exp_rd("par_ok_err", A_ERR, 0);
    exp_rd("par_ok_cnt", A_RXCNT, 1);
    rd_sb("par_ok_data");
    wr(A_CTRL, 8'h00);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) sb.push_back(8'(8'hA0 + i * 7));
      send(8'(8'hA0 + i * 7), 1'b0, 1'b0, 1'b1);
    end
    chk("ovr_not_empty", 32'(rx_q_empty), 0);
    exp_rd("ovr_cnt", A_RXCNT, 8);
    exp_rd("ovr_err", A_ERR, 'h02);
    for (int i = 0; i < 8; i++) rd_sb("ovr_data");
    chk("ovr_drained", 32'(rx_q_empty), 1);
    wr(A_ERR, 8'h0F);
    @(negedge clk);
    RX = 1'b0;
    @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    exp_rd("glitch_cnt", A_RXCNT, 0);
    exp_rd("glitch_err", A_ERR, 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
